alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives datapath control strobes for preloads and ALU ops.
// Optional SEQ_SINGLE_STEP_EN: non-IDLE states advance only when step=1.
module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 16,
  localparam int REG_W = $clog2(NUM_REGS)
) (
  input  logic              Clock,
  input  logic              clr,
  output logic              ready,
  input  logic              pre_valid,
  input  logic [REG_W-1:0]  pre_reg,
  input  logic [DATA_W-1:0] pre_data,
  input  logic              start,
  input  logic [DATA_W-1:0] instr,
  input  logic              step,
  output logic              done,
  output logic              PCout,
  output logic              Zlowout,
  output logic              MDRout,
  output logic              MARin,
  output logic              Zin,
  output logic              PCin,
  output logic              MDRin,
  output logic              IRin,
  output logic              Yin,
  output logic              IncPC,
  output logic              Read,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [4:0]        ALU_select,
  output logic [DATA_W-1:0] Mdatain
);

  if (DATA_W < 5 + 3 * REG_W) begin : g_bad_width
    $error("DATA_W too narrow for opcode and three register fields");
  end
  if (NUM_REGS != (1 << REG_W)) begin : g_bad_regs
    $error("NUM_REGS must be a power of two");
  end

  typedef enum logic [3:0] {
    IDLE, LD_A, LD_B, T0, T1, T2, T3, T4, T5
  } state_t;

  state_t state_q, state_d;

  logic [REG_W-1:0]  reg_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] instr_q;

  logic [4:0]       opcode;
  logic [REG_W-1:0] ra, rb, rc;
  logic             adv;

  assign opcode = instr_q[DATA_W-1 -: 5];
  assign ra = instr_q[DATA_W-6 -: REG_W];
  assign rb = instr_q[DATA_W-6-REG_W -: REG_W];
  assign rc = instr_q[DATA_W-6-2*REG_W -: REG_W];

`ifdef SEQ_SINGLE_STEP_EN
  assign adv = step;
`else
  logic unused_step;
  assign unused_step = step;
  assign adv = 1'b1;
`endif

  // State register and request field capture, only while IDLE.
  always_ff @(posedge Clock or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      reg_q <= '0;
      data_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (pre_valid) begin
          reg_q <= pre_reg;
          data_q <= pre_data;
        end else if (start) begin
          instr_q <= instr;
        end
      end
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    state_d = state_q;
    ready = 1'b0;
    done = 1'b0;
    PCout = 1'b0;
    Zlowout = 1'b0;
    MDRout = 1'b0;
    MARin = 1'b0;
    Zin = 1'b0;
    PCin = 1'b0;
    MDRin = 1'b0;
    IRin = 1'b0;
    Yin = 1'b0;
    IncPC = 1'b0;
    Read = 1'b0;
    Rin = '0;
    Rout = '0;
    ALU_select = '0;
    Mdatain = '0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (pre_valid) state_d = LD_A;
        else if (start) state_d = T0;
      end
      LD_A: begin
        Mdatain = data_q;
        Read = 1'b1;
        MDRin = 1'b1;
        if (adv) state_d = LD_B;
      end
      LD_B: begin
        MDRout = 1'b1;
        Rin[reg_q] = 1'b1;
        if (adv) state_d = IDLE;
      end
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin = 1'b1;
        if (adv) state_d = T1;
      end
      T1: begin
        Zlowout = 1'b1;
        PCin = 1'b1;
        Read = 1'b1;
        MDRin = 1'b1;
        Mdatain = instr_q;
        if (adv) state_d = T2;
      end
      T2: begin
        MDRout = 1'b1;
        IRin = 1'b1;
        if (adv) state_d = T3;
      end
      T3: begin
        Rout[rb] = 1'b1;
        Yin = 1'b1;
        if (adv) state_d = T4;
      end
      T4: begin
        Rout[rc] = 1'b1;
        Zin = 1'b1;
        ALU_select = opcode;
        if (adv) state_d = T5;
      end
      T5: begin
        Zlowout = 1'b1;
        Rin[ra] = 1'b1;
        done = 1'b1;
        if (adv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench for alu_op_sequencer.
// Expected per-cycle output vectors are queued, then popped and compared.
module tb_alu_op_sequencer;

  logic        Clock;
  logic        clr;
  logic        ready;
  logic        pre_valid;
  logic [3:0]  pre_reg;
  logic [31:0] pre_data;
  logic        start;
  logic [31:0] instr;
  logic        step;
  logic        done;
  logic        PCout, Zlowout, MDRout, MARin, Zin, PCin;
  logic        MDRin, IRin, Yin, IncPC, Read;
  logic [15:0] Rin, Rout;
  logic [4:0]  ALU_select;
  logic [31:0] Mdatain;

  alu_op_sequencer #(.DATA_W(32), .NUM_REGS(16)) dut (
    .Clock(Clock), .clr(clr), .ready(ready),
    .pre_valid(pre_valid), .pre_reg(pre_reg), .pre_data(pre_data),
    .start(start), .instr(instr), .step(step), .done(done),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin),
    .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .Rin(Rin), .Rout(Rout),
    .ALU_select(ALU_select), .Mdatain(Mdatain)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  localparam logic [10:0] S_PCOUT = 11'h400;
  localparam logic [10:0] S_ZLOW = 11'h200;
  localparam logic [10:0] S_MDROUT = 11'h100;
  localparam logic [10:0] S_MARIN = 11'h080;
  localparam logic [10:0] S_ZIN = 11'h040;
  localparam logic [10:0] S_PCIN = 11'h020;
  localparam logic [10:0] S_MDRIN = 11'h010;
  localparam logic [10:0] S_IRIN = 11'h008;
  localparam logic [10:0] S_YIN = 11'h004;
  localparam logic [10:0] S_INCPC = 11'h002;
  localparam logic [10:0] S_READ = 11'h001;

  logic [81:0] sb[$];
  int checks = 0;
  int passed = 0;

  function automatic logic [81:0] mk(
    input logic r, input logic d, input logic [10:0] s,
    input logic [15:0] ri, input logic [15:0] ro,
    input logic [4:0] alu, input logic [31:0] md);
    return {r, d, s, ri, ro, alu, md};
  endfunction

  function automatic logic [81:0] idle_v();
    return mk(1'b1, 1'b0, 11'h0, 16'h0, 16'h0, 5'h0, 32'h0);
  endfunction

  // Reference model of one instruction cycle t (0..5 = T0..T5, else IDLE).
  function automatic logic [81:0] tstate(input int t, input logic [31:0] ins);
    logic [4:0]  op;
    logic [15:0] a, b, c;
    op = ins[31:27];
    a = 16'h1 << ins[26:23];
    b = 16'h1 << ins[22:19];
    c = 16'h1 << ins[18:15];
    case (t)
      0: return mk(0, 0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 0, 0, 0, 0);
      1: return mk(0, 0, S_ZLOW | S_PCIN | S_READ | S_MDRIN, 0, 0, 0, ins);
      2: return mk(0, 0, S_MDROUT | S_IRIN, 0, 0, 0, 0);
      3: return mk(0, 0, S_YIN, 0, b, 0, 0);
      4: return mk(0, 0, S_ZIN, 0, c, op, 0);
      5: return mk(0, 1, S_ZLOW, a, 0, 0, 0);
      default: return idle_v();
    endcase
  endfunction

  function automatic logic [81:0] obs();
    return {ready, done, PCout, Zlowout, MDRout, MARin, Zin, PCin,
            MDRin, IRin, Yin, IncPC, Read, Rin, Rout, ALU_select, Mdatain};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    logic [81:0] o, e;
    clr = 1'b0;
    #3;
    sb.push_back(idle_v());
    o = obs(); e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL reset_init got %h want %h", o, e);
    else passed++;
    tick();
    clr = 1'b1;
    start = 1'b1;
    instr = 32'h4A920000;
    sb.push_back(tstate(0, instr));
    sb.push_back(tstate(1, instr));
    for (int i = 0; i < 2; i++) begin
      tick(); start = 1'b0;
      o = obs(); e = sb.pop_front(); checks++;
      if (o !== e) $display("FAIL reset_run[%0d] got %h want %h", i, o, e);
      else passed++;
    end
    #2 clr = 1'b0;
    #1;
    sb.push_back(idle_v());
    o = obs(); e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL reset_async got %h want %h", o, e);
    else passed++;
    tick();
    clr = 1'b1;
    for (int i = 0; i < 5; i++) sb.push_back(idle_v());
    for (int i = 0; i < 5; i++) begin
      tick();
      o = obs(); e = sb.pop_front(); checks++;
      if (o !== e) $display("FAIL reset_idle[%0d] got %h want %h", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_preload();
    logic [81:0] o, e;
    pre_valid = 1'b1;
    pre_reg = 4'd2;
    pre_data = 32'h22;
    sb.push_back(mk(0, 0, S_MDRIN | S_READ, 0, 0, 0, 32'h22));
    sb.push_back(mk(0, 0, S_MDROUT, 16'h0004, 0, 0, 0));
    sb.push_back(idle_v());
    for (int i = 0; i < 3; i++) begin
      tick(); pre_valid = 1'b0;
      o = obs(); e = sb.pop_front(); checks++;
      if (o !== e) $display("FAIL preload[%0d] got %h want %h", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [81:0] o, e;
    logic [3:0]  regs[3];
    logic [31:0] vals[3];
    regs = '{4'd4, 4'd5, 4'd15};
    vals = '{32'h24, 32'h26, 32'hFFFF_FFFF};
    for (int j = 0; j < 3; j++) begin
      pre_valid = 1'b1;
      pre_reg = regs[j];
      pre_data = vals[j];
      sb.push_back(mk(0, 0, S_MDRIN | S_READ, 0, 0, 0, vals[j]));
      sb.push_back(mk(0, 0, S_MDROUT, 16'h1 << regs[j], 0, 0, 0));
      sb.push_back(idle_v());
      for (int i = 0; i < 3; i++) begin
        tick(); pre_valid = 1'b0;
        o = obs(); e = sb.pop_front(); checks++;
        if (o !== e)
          $display("FAIL b2b_pre[%0d][%0d] got %h want %h", j, i, o, e);
        else passed++;
      end
    end
  endtask

  task automatic test_instr(input logic [31:0] ins);
    logic [81:0] o, e;
    start = 1'b1;
    instr = ins;
    for (int t = 0; t < 7; t++) sb.push_back(tstate(t, ins));
    for (int t = 0; t < 7; t++) begin
      tick(); start = 1'b0;
      o = obs(); e = sb.pop_front(); checks++;
      if (o !== e)
        $display("FAIL instr_%h_T%0d got %h want %h", ins, t, o, e);
      else passed++;
    end
  endtask

  task automatic test_collision();
    logic [81:0] o, e;
    pre_valid = 1'b1;
    start = 1'b1;
    pre_reg = 4'd3;
    pre_data = 32'h33;
    instr = 32'h4A920000;
    sb.push_back(mk(0, 0, S_MDRIN | S_READ, 0, 0, 0, 32'h33));
    sb.push_back(mk(0, 0, S_MDROUT, 16'h0008, 0, 0, 0));
    sb.push_back(idle_v());
    sb.push_back(idle_v());
    sb.push_back(idle_v());
    for (int i = 0; i < 5; i++) begin
      tick(); pre_valid = 1'b0; start = 1'b0;
      o = obs(); e = sb.pop_front(); checks++;
      if (o !== e) $display("FAIL collision[%0d] got %h want %h", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_abort();
    logic [81:0] o, e;
    start = 1'b1;
    instr = 32'h4A920000;
    for (int t = 0; t < 5; t++) sb.push_back(tstate(t, instr));
    for (int t = 0; t < 5; t++) begin
      tick(); start = 1'b0;
      o = obs(); e = sb.pop_front(); checks++;
      if (o !== e) $display("FAIL abort_T%0d got %h want %h", t, o, e);
      else passed++;
    end
    #2 clr = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) sb.push_back(idle_v());
    o = obs(); e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL abort_async got %h want %h", o, e);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 2) clr = 1'b1;
      o = obs(); e = sb.pop_front(); checks++;
      if (o !== e) $display("FAIL abort_after[%0d] got %h want %h", i, o, e);
      else passed++;
    end
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    logic [81:0] o, e;
    start = 1'b1;
    instr = 32'h4A920000;
    for (int i = 0; i < 10; i++) sb.push_back(tstate(0, instr));
    for (int i = 0; i < 10; i++) begin
      tick(); start = 1'b0;
      o = obs(); e = sb.pop_front(); checks++;
      if (o !== e) $display("FAIL step_hold[%0d] got %h want %h", i, o, e);
      else passed++;
    end
    for (int t = 1; t < 7; t++) begin
      step = 1'b1;
      sb.push_back(tstate(t, instr));
      sb.push_back(tstate(t, instr));
      tick(); step = 1'b0;
      o = obs(); e = sb.pop_front(); checks++;
      if (o !== e) $display("FAIL step_T%0d got %h want %h", t, o, e);
      else passed++;
      tick();
      o = obs(); e = sb.pop_front(); checks++;
      if (o !== e) $display("FAIL step_dwell_T%0d got %h want %h", t, o, e);
      else passed++;
    end
  endtask
`endif

  initial begin
    clr = 1'b0;
    pre_valid = 1'b0;
    pre_reg = '0;
    pre_data = '0;
    start = 1'b0;
    instr = '0;
    step = 1'b0;
    test_reset();
    test_preload();
    test_back_to_back();
    test_instr(32'h4A920000);
    test_instr({5'b00011, 4'd7, 4'd7, 4'd7, 15'h1234});
    test_instr({5'b11111, 4'd15, 4'd0, 4'd15, 15'h7FFF});
    test_instr($urandom);
    test_collision();
    test_abort();
`ifdef SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
